// File: rtl/shad_reg_scan_ctrl.sv
// Capture/shift sequencer for a shadow-register pair; optional periodic capture under SHAD_SCAN_CTRL_AUTO_CAPTURE_EN.
// Latency cap_req->rd_valid WIDTH+2 cycles; rd_valid holds in DONE until rd_ack, new requests wait for IDLE.
module shad_reg_scan_ctrl #(
    parameter int WIDTH  = 8,
    parameter bit RECIRC = 1'b1
`ifdef SHAD_SCAN_CTRL_AUTO_CAPTURE_EN
    ,
    parameter int AUTO_PERIOD = 1024
`endif
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             cap_req,
    output logic             cap_busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ack,
    output logic             shad_ce,
    output logic             shad_se,
    output logic             shad_si,
    input  logic             shad_so
`ifdef SHAD_SCAN_CTRL_AUTO_CAPTURE_EN
    ,
    input  logic             auto_en,
    output logic             auto_ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CAP, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             start_req;

`ifdef SHAD_SCAN_CTRL_AUTO_CAPTURE_EN
    localparam int AP_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    logic [AP_W-1:0] ap_cnt_q;
    logic            pend_q, ovf_q;
    logic            wrap, post;

    assign wrap = (ap_cnt_q == AP_W'(AUTO_PERIOD - 1));
    assign post = wrap && auto_en;

    // A pending request is consumed in IDLE; a wrap landing on an unconsumed one is an overflow.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            ap_cnt_q <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ap_cnt_q <= wrap ? '0 : ap_cnt_q + AP_W'(1);
            pend_q   <= post || (pend_q && (state_q != IDLE));
            if (post && pend_q && (state_q != IDLE))
                ovf_q <= 1'b1;
        end
    end

    assign start_req = cap_req || pend_q;
    assign auto_ovf  = ovf_q;
`else
    assign start_req = cap_req;
`endif

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (start_req)
                    state_d = CAP;
            end
            CAP: begin
                cnt_d   = CNT_W'(WIDTH);
                state_d = SHIFT;
            end
            SHIFT: begin
                // Shadow MSB appears on SO first, so the word fills from the LSB side.
                rd_data_d = {rd_data_q[WIDTH-2:0], shad_so};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                if (rd_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cap_busy = (state_q != IDLE);
    assign rd_valid = (state_q == DONE);
    assign rd_data  = rd_data_q;
    assign shad_ce  = (state_q == CAP) || (state_q == SHIFT);
    assign shad_se  = (state_q == SHIFT);
    assign shad_si  = (state_q == SHIFT) && RECIRC && shad_so;

endmodule
